// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling, glitch/framing rejection and an
// 8-bit first-word-fall-through FIFO between the line and the consumer.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 5207,
    parameter int FIFO_AW      = 3
) (
    input  logic       sysclk,
    input  logic       reset_n,
    input  logic       serial_in,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       full,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [12:0] DIV_LAST = 13'(CLKS_PER_BIT - 1);
    localparam logic [12:0] DIV_MID  = 13'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    rx_state_t state_reg, state_next;

    logic        s1_reg, s2_reg, s_prev_reg;
    logic [12:0] div_reg, div_next;
    logic [2:0]  bidx_reg, bidx_next;
    logic [7:0]  shreg_reg, shreg_next;
    logic        fall;
    logic        stop_good, stop_bad;

    logic [7:0]         mem_reg [DEPTH];
    logic [FIFO_AW-1:0] wptr_reg, rptr_reg;
    logic [FIFO_AW:0]   count_reg;
    logic               frame_err_reg, overrun_reg;
    logic               push, pop, drop;

    // Synchroniser idles high so a line already low at release yields one edge.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            s1_reg     <= 1'b1;
            s2_reg     <= 1'b1;
            s_prev_reg <= 1'b1;
        end else begin
            s1_reg     <= serial_in;
            s2_reg     <= s1_reg;
            s_prev_reg <= s2_reg;
        end
    end

    assign fall = s_prev_reg & ~s2_reg;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            div_reg   <= '0;
            bidx_reg  <= '0;
            shreg_reg <= '0;
        end else begin
            state_reg <= state_next;
            div_reg   <= div_next;
            bidx_reg  <= bidx_next;
            shreg_reg <= shreg_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        bidx_next  = bidx_reg;
        shreg_next = shreg_reg;
        stop_good  = 1'b0;
        stop_bad   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fall) begin
                    div_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (div_reg == DIV_MID) begin
                    if (!s2_reg) begin
                        div_next   = '0;
                        bidx_next  = '0;
                        state_next = DATA;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    div_next = div_reg + 13'd1;
                end
            end
            DATA: begin
                if (div_reg == DIV_LAST) begin
                    shreg_next = {s2_reg, shreg_reg[7:1]};
                    div_next   = '0;
                    if (bidx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bidx_next = bidx_reg + 3'd1;
                    end
                end else begin
                    div_next = div_reg + 13'd1;
                end
            end
            STOP: begin
                if (div_reg == DIV_LAST) begin
                    if (s2_reg) begin
                        stop_good  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = BREAK;
                    end
                end else begin
                    div_next = div_reg + 13'd1;
                end
            end
            BREAK: begin
                if (s2_reg) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rd_valid = (count_reg != '0);
    assign full     = (count_reg == (FIFO_AW + 1)'(DEPTH));
    assign pop      = rd_en & rd_valid;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push     = stop_good & (~full | pop);
    assign drop     = stop_good & full & ~pop;

    always_ff @(posedge sysclk) begin
        if (push) begin
            mem_reg[wptr_reg] <= shreg_reg;
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            count_reg     <= '0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            frame_err_reg <= stop_bad;
            overrun_reg   <= drop;
            if (push) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
            if (pop) begin
                rptr_reg <= rptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_data   = rd_valid ? mem_reg[rptr_reg] : 8'h00;
    assign rx_busy   = (state_reg != IDLE);
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: frame-level line driver, queue-based FIFO model with
// stop-sample timing derived from the latency rules, and directed scenarios.
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int STOP_OFS = 3 + CPB / 2 + 9 * CPB;

    logic       sysclk = 1'b0;
    logic       reset_n = 1'b0;
    logic       serial_in = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid, full, rx_busy, frame_err, overrun;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .sysclk    (sysclk),
        .reset_n   (reset_n),
        .serial_in (serial_in),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .full      (full),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 sysclk = ~sysclk;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int n_ferr = 0;
    int n_ovr = 0;
    int last_stop = 0;
    bit done_tx = 0;
    logic [7:0] mq[$];
    int ev_kind[int];
    logic [7:0] ev_data[int];
    logic exp_ferr = 1'b0;
    logic exp_ovr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: FIFO as a queue; a frame's outcome lands on its stop-sample edge.
    initial begin
        forever begin
            @(posedge sysclk);
            cyc = cyc + 1;
            exp_ferr = 1'b0;
            exp_ovr  = 1'b0;
            if (!reset_n) begin
                mq.delete();
            end else begin
                if (rd_en && mq.size() > 0) void'(mq.pop_front());
                if (ev_kind.exists(cyc)) begin
                    if (ev_kind[cyc] == 1) begin
                        if (mq.size() < DEPTH) mq.push_back(ev_data[cyc]);
                        else exp_ovr = 1'b1;
                    end else begin
                        exp_ferr = 1'b1;
                    end
                    ev_kind.delete(cyc);
                    ev_data.delete(cyc);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge sysclk);
            if (!reset_n) begin
                chk("rst_rd_valid", rd_valid, 0);
                chk("rst_rd_data", rd_data, 0);
                chk("rst_full", full, 0);
                chk("rst_rx_busy", rx_busy, 0);
                chk("rst_frame_err", frame_err, 0);
                chk("rst_overrun", overrun, 0);
            end else begin
                chk("rd_valid", rd_valid, mq.size() != 0);
                chk("rd_data", rd_data, (mq.size() != 0) ? mq[0] : 8'h00);
                chk("full", full, mq.size() == DEPTH);
                chk("frame_err", frame_err, exp_ferr);
                chk("overrun", overrun, exp_ovr);
            end
            if (frame_err === 1'b1) n_ferr++;
            if (overrun === 1'b1) n_ovr++;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Called in the posedge+1 phase; returns in the same phase CPB edges later.
    task automatic bit_time(input logic v);
        serial_in = v;
        repeat (CPB) @(posedge sysclk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int hold_low);
        int n;
        @(posedge sysclk);
        #1;
        n = cyc;
        ev_kind[n + STOP_OFS] = stop_ok ? 1 : 2;
        ev_data[n + STOP_OFS] = b;
        last_stop = n + STOP_OFS;
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        if (stop_ok) begin
            bit_time(1'b1);
        end else begin
            serial_in = 1'b0;
            repeat (hold_low) @(posedge sysclk);
            #1;
            bit_time(1'b1);
        end
    endtask

    task automatic pop_one();
        @(posedge sysclk);
        #1 rd_en = 1'b1;
        @(posedge sysclk);
        #1 rd_en = 1'b0;
    endtask

    initial begin
        int base;
        int waited;
        logic [7:0] exp_drain[8];

        repeat (3) @(posedge sysclk);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge sysclk);

        // Single byte
        send_frame(8'h41, 1'b1, 0);
        @(negedge sysclk);
        chk("single_valid", rd_valid, 1);
        chk("single_data", rd_data, 8'h41);
        chk("single_idle", rx_busy, 0);
        pop_one();
        @(negedge sysclk);
        chk("single_popped_valid", rd_valid, 0);
        chk("single_popped_data", rd_data, 8'h00);
        $display("txn single byte 41 done, cycle %0d", cyc);

        // Glitch start
        @(posedge sysclk);
        #1 serial_in = 1'b0;
        repeat (3) @(posedge sysclk);
        #1 serial_in = 1'b1;
        @(negedge sysclk);
        chk("glitch_busy", rx_busy, 1);
        waited = 0;
        while (rx_busy === 1'b1 && waited < 20) begin
            @(negedge sysclk);
            waited++;
        end
        chk("glitch_idle_in_9", (waited <= 9), 1);
        chk("glitch_no_ferr", n_ferr, 0);
        repeat (CPB) @(posedge sysclk);
        chk("glitch_no_push", rd_valid, 0);
        $display("txn glitch start, idle after %0d cycles", waited);

        // Framing error then a good byte
        base = n_ferr;
        send_frame(8'h55, 1'b0, 40);
        chk("ferr_count", n_ferr - base, 1);
        chk("ferr_fifo_empty", rd_valid, 0);
        send_frame(8'h08, 1'b1, 0);
        @(negedge sysclk);
        chk("after_ferr_data", rd_data, 8'h08);
        pop_one();
        $display("txn framing error 55 then 08, cycle %0d", cyc);

        // Fill and overrun
        base = n_ovr;
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 1'b1, 0);
            if (i == 8) chk("full_after_8", full, 1);
        end
        chk("overrun_once", n_ovr - base, 1);
        @(posedge sysclk);
        #1 rd_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge sysclk);
            chk("drain_fill", rd_data, i);
            if (i < 8) @(posedge sysclk);
        end
        @(posedge sysclk);
        #1 rd_en = 1'b0;
        @(negedge sysclk);
        chk("drain_fill_empty", rd_valid, 0);
        $display("txn fill 01..09 with overrun, cycle %0d", cyc);

        // Push and pop on the same edge while full
        for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b1, 0);
        chk("full_before_aa", full, 1);
        base = n_ovr;
        last_stop = 0;
        fork
            send_frame(8'hAA, 1'b1, 0);
            begin
                @(posedge sysclk);
                #2;
                while (cyc != last_stop - 1) begin
                    @(posedge sysclk);
                    #1;
                end
                rd_en = 1'b1;
                @(posedge sysclk);
                #1 rd_en = 1'b0;
            end
        join
        chk("aa_no_overrun", n_ovr - base, 0);
        chk("aa_still_full", full, 1);
        for (int i = 0; i < 7; i++) exp_drain[i] = 8'h12 + 8'(i);
        exp_drain[7] = 8'hAA;
        @(posedge sysclk);
        #1 rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge sysclk);
            chk("drain_aa", rd_data, exp_drain[i]);
            if (i < 7) @(posedge sysclk);
        end
        @(posedge sysclk);
        #1 rd_en = 1'b0;
        $display("txn push+pop while full with AA, cycle %0d", cyc);

        // Reset in the middle of data bit 4
        send_frame(8'h33, 1'b1, 0);
        @(posedge sysclk);
        #1;
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(i[0]);
        serial_in = 1'b1;
        repeat (8) @(posedge sysclk);
        @(negedge sysclk);
        chk("pre_rst_busy", rx_busy, 1);
        chk("pre_rst_valid", rd_valid, 1);
        @(posedge sysclk);
        #3 reset_n = 1'b0;
        #1;
        chk("rst_now_valid", rd_valid, 0);
        chk("rst_now_data", rd_data, 8'h00);
        chk("rst_now_busy", rx_busy, 0);
        chk("rst_now_full", full, 0);
        repeat (3) @(posedge sysclk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge sysclk);
        send_frame(8'h7E, 1'b1, 0);
        @(negedge sysclk);
        chk("post_rst_valid", rd_valid, 1);
        chk("post_rst_data", rd_data, 8'h7E);
        pop_one();
        $display("txn reset mid-frame then 7E, cycle %0d", cyc);

        // Random traffic with concurrent random reads
        done_tx = 0;
        fork
            begin
                for (int k = 0; k < 24; k++) begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    if ($urandom_range(5) == 0) send_frame(b, 1'b0, 20);
                    else send_frame(b, 1'b1, 0);
                    repeat ($urandom_range(12)) @(posedge sysclk);
                end
                done_tx = 1;
            end
            begin
                while (!done_tx) begin
                    @(posedge sysclk);
                    #1 rd_en = ($urandom_range(3) == 0);
                end
                rd_en = 1'b0;
            end
        join
        @(posedge sysclk);
        #1 rd_en = 1'b1;
        repeat (DEPTH + 2) @(posedge sysclk);
        #1 rd_en = 1'b0;
        @(negedge sysclk);
        chk("random_drained", rd_valid, 0);
        $display("txn random traffic done, ferr=%0d ovr=%0d, cycle %0d", n_ferr, n_ovr, cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
